// File: rtl/fifo_frame_reader.sv
// Pops words from a non-show-ahead FIFO, packs WORDS of them into one frame and
// hands the frame downstream over a valid/ready handshake.
module fifo_frame_reader #(
   parameter int WIDTH = 64,
   parameter int WORDS = 4
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   RDEMPTY,
   input  logic [WIDTH-1:0]       Q,
   output logic                   RDREQ,
   input  logic                   FLUSH,
   output logic [WORDS*WIDTH-1:0] FRAME,
   output logic                   FRAME_VALID,
   input  logic                   FRAME_READY,
   output logic [15:0]            FRAME_COUNT
);

   localparam int CW = $clog2(WORDS + 1);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    issued;
   logic [IW-1:0]    idx;
   logic             in_flight;
   logic             frame_valid;
   logic [15:0]      frame_count;
   logic [WIDTH-1:0] frame_q [WORDS];

   logic             rdreq_c;
   logic             capture;
   logic             accept;
   logic             clear;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      rdreq_c    = 1'b0;
      capture    = 1'b0;
      accept     = 1'b0;
      clear      = 1'b0;
      case (state)
         IDLE: begin
            next_state = READ;
         end
         READ: begin
            rdreq_c = !RDEMPTY && (issued < WORDS_C) && !FLUSH;
            // A word already popped when FLUSH arrives is simply not written
            capture = in_flight && !FLUSH;
            clear   = FLUSH;
            if (capture && (idx == LAST_IDX)) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            accept = frame_valid && FRAME_READY && !FLUSH;
            if (FLUSH || accept) begin
               clear      = 1'b1;
               next_state = READ;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         issued      <= '0;
         idx         <= '0;
         in_flight   <= 1'b0;
         frame_valid <= 1'b0;
         frame_count <= '0;
         for (int i = 0; i < WORDS; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         // Q is valid the cycle after RDREQ, so in_flight marks the word to capture
         in_flight <= rdreq_c;
         if (clear) begin
            issued <= '0;
            idx    <= '0;
         end else begin
            if (rdreq_c) begin
               issued <= issued + 1'b1;
            end
            if (capture) begin
               idx <= idx + 1'b1;
            end
         end
         if (capture) begin
            frame_q[idx] <= Q;
         end
         if (capture && (idx == LAST_IDX)) begin
            frame_valid <= 1'b1;
         end else if ((state == HOLD) && clear) begin
            frame_valid <= 1'b0;
         end
         if (accept) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < WORDS; g++) begin : g_frame
      assign FRAME[g*WIDTH +: WIDTH] = frame_q[g];
   end

   assign RDREQ       = rdreq_c;
   assign FRAME_VALID = frame_valid;
   assign FRAME_COUNT = frame_count;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a latency-1 FIFO model feeds the reader
// while frames, timing, stalls, backpressure, flushes and count wrap are checked.
module tb_fifo_frame_reader;

   localparam int WIDTH = 64;
   localparam int WORDS = 4;

   logic                   CLK = 1'b0;
   logic                   nRST = 1'b0;
   logic                   RDEMPTY;
   logic [WIDTH-1:0]       Q = '0;
   logic                   RDREQ;
   logic                   FLUSH = 1'b0;
   logic [WORDS*WIDTH-1:0] FRAME;
   logic                   FRAME_VALID;
   logic                   FRAME_READY = 1'b1;
   logic [15:0]            FRAME_COUNT;

   logic [WIDTH-1:0] mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops = 0;
   int bad_pops = 0;
   int checks = 0;
   int failures = 0;

   fifo_frame_reader #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .CLK(CLK),
      .nRST(nRST),
      .RDEMPTY(RDEMPTY),
      .Q(Q),
      .RDREQ(RDREQ),
      .FLUSH(FLUSH),
      .FRAME(FRAME),
      .FRAME_VALID(FRAME_VALID),
      .FRAME_READY(FRAME_READY),
      .FRAME_COUNT(FRAME_COUNT)
   );

   always #5 CLK = ~CLK;

   // Non-show-ahead FIFO: data appears on Q the cycle after the request
   assign RDEMPTY = (rd_ptr == wr_ptr);
   always @(posedge CLK) begin
      if (RDREQ) begin
         if (rd_ptr == wr_ptr) begin
            bad_pops <= bad_pops + 1;
         end else begin
            Q      <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
         end
         pops <= pops + 1;
      end
   end

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] v);
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!FRAME_VALID && n < 60);
      if (!FRAME_VALID) n = -1;
   endtask

   function automatic logic [WORDS*WIDTH-1:0] fr(input logic [WIDTH-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;
      int rq;
      logic stable;
      logic [WORDS*WIDTH-1:0] saved;

      // Reset with the FIFO already holding data
      for (int i = 1; i <= 8; i++) push(64'(i * 17));
      step(3);
      chk("rst_rdreq", RDREQ, 0);
      chk("rst_valid", FRAME_VALID, 0);
      chk("rst_count", FRAME_COUNT, 0);
      chk("rst_frame", FRAME, 0);
      nRST = 1'b1;
      #1;
      chk("idle_rdreq", RDREQ, 0);
      step(1);
      chk("first_rdreq", RDREQ, 1);

      // Back-to-back frames with READY held high
      wait_valid(n);
      chk("lat", n, 5);
      chk("frame0", FRAME, fr(64'h11, 64'h22, 64'h33, 64'h44));
      wait_valid(n);
      chk("period", n, 6);
      chk("frame1", FRAME, fr(64'h55, 64'h66, 64'h77, 64'h88));
      step(1);
      chk("count2", FRAME_COUNT, 2);
      chk("pops8", pops, 8);
      chk("empty_rdreq", RDREQ, 0);

      // Underflow stall after two words
      p0 = pops;
      push(64'hDEAD_BEEF_0000_00A1);
      push(64'hDEAD_BEEF_0000_00A2);
      #1;
      rq = 0;
      for (int i = 0; i < 12; i++) begin
         rq += int'(RDREQ);
         step(1);
      end
      chk("stall_rdreq", rq, 2);
      chk("stall_pops", pops - p0, 2);
      chk("stall_valid", FRAME_VALID, 0);
      push(64'hDEAD_BEEF_0000_00A3);
      push(64'hFFFF_FFFF_FFFF_FFA4);
      wait_valid(n);
      chk("stall_frame", FRAME, fr(64'hDEAD_BEEF_0000_00A1, 64'hDEAD_BEEF_0000_00A2,
                                   64'hDEAD_BEEF_0000_00A3, 64'hFFFF_FFFF_FFFF_FFA4));
      step(1);
      chk("count3", FRAME_COUNT, 3);

      // Backpressure: READY low for 20 cycles with more data waiting
      FRAME_READY = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'(16'hB000 + i));
      wait_valid(n);
      saved = FRAME;
      for (int i = 1; i <= 4; i++) push(64'(16'hC000 + i));
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         stable = stable & (FRAME == saved) & FRAME_VALID & !RDREQ & (FRAME_COUNT == 16'd3);
      end
      chk("bp_stable", stable, 1);
      chk("bp_frame", saved, fr(64'hB001, 64'hB002, 64'hB003, 64'hB004));
      FRAME_READY = 1'b1;
      step(1);
      chk("bp_count", FRAME_COUNT, 4);
      chk("bp_valid", FRAME_VALID, 0);
      wait_valid(n);
      chk("bp_next", FRAME, fr(64'hC001, 64'hC002, 64'hC003, 64'hC004));
      step(1);
      chk("count5", FRAME_COUNT, 5);

      // FLUSH while partially collected and stalled
      p0 = pops;
      push(64'hD1);
      push(64'hD2);
      step(4);
      FLUSH = 1'b1;
      step(1);
      FLUSH = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'(16'hE000 + i));
      wait_valid(n);
      chk("flush_frame", FRAME, fr(64'hE001, 64'hE002, 64'hE003, 64'hE004));
      chk("flush_pops", pops - p0, 6);
      step(1);
      chk("count6", FRAME_COUNT, 6);

      // FLUSH with the third word in flight
      p0 = pops;
      for (int i = 1; i <= 7; i++) push(64'(16'hF000 + i));
      step(3);
      FLUSH = 1'b1;
      step(1);
      FLUSH = 1'b0;
      wait_valid(n);
      chk("inflight_frame", FRAME, fr(64'hF004, 64'hF005, 64'hF006, 64'hF007));
      chk("inflight_pops", pops - p0, 7);
      step(1);
      chk("count7", FRAME_COUNT, 7);

      // FLUSH in HOLD beats a simultaneous READY
      for (int i = 1; i <= 4; i++) push(64'(16'h6000 + i));
      wait_valid(n);
      chk("hold_frame", FRAME, fr(64'h6001, 64'h6002, 64'h6003, 64'h6004));
      FLUSH = 1'b1;
      step(1);
      FLUSH = 1'b0;
      chk("hflush_valid", FRAME_VALID, 0);
      chk("hflush_count", FRAME_COUNT, 7);
      for (int i = 1; i <= 4; i++) push(64'(16'h7000 + i));
      wait_valid(n);
      chk("hflush_next", FRAME, fr(64'h7001, 64'h7002, 64'h7003, 64'h7004));
      step(1);
      chk("count8", FRAME_COUNT, 8);

      // Reset mid-frame discards the partial frame and the count
      push(64'h9001);
      push(64'h9002);
      step(4);
      nRST = 1'b0;
      step(2);
      chk("mrst_frame", FRAME, 0);
      chk("mrst_count", FRAME_COUNT, 0);
      chk("mrst_rdreq", RDREQ, 0);
      nRST = 1'b1;
      p0 = pops;
      for (int i = 1; i <= 4; i++) push(64'(16'h8000 + i));
      wait_valid(n);
      chk("mrst_next", FRAME, fr(64'h8001, 64'h8002, 64'h8003, 64'h8004));
      chk("mrst_pops", pops - p0, 4);
      step(1);
      chk("mrst_count1", FRAME_COUNT, 1);

      // Count wrap, preloading the counter while a frame is held
      FRAME_READY = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'(16'h5000 + i));
      wait_valid(n);
      dut.frame_count = 16'hFFFF;
      step(1);
      chk("wrap_pre", FRAME_COUNT, 16'hFFFF);
      FRAME_READY = 1'b1;
      step(1);
      chk("wrap", FRAME_COUNT, 0);
      chk("bad_pops", bad_pops, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
